// File: rtl/bids22_cmd_sequencer.sv
// Command sequencer for bids22: a FIFO of host commands that are replayed onto the
// controller port, paced by ready, with bidding-round timing and a sticky error halt.
module bids22_cmd_sequencer #(
    parameter int DATAWIDTH = 32,
    parameter int OPW       = 4,
    parameter int ERRW      = 4,
    parameter int DEPTH     = 8,
    parameter int SETTLEMAX = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OPW-1:0]       cmd_op,
    input  logic [DATAWIDTH-1:0] cmd_data,
    input  logic                 cmd_start,
    output logic [OPW-1:0]       C_op,
    output logic [DATAWIDTH-1:0] C_data,
    output logic                 C_start,
    input  logic                 ready,
    input  logic [ERRW-1:0]      err,
    output logic                 busy,
    output logic                 halted,
    output logic [ERRW-1:0]      err_code,
    output logic [OPW-1:0]       err_op,
    output logic                 timeout,
    input  logic                 clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + OPW + DATAWIDTH;
    localparam int SW = $clog2(SETTLEMAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        CHECK  = 3'd2,
        ROUND  = 3'd3,
        DRAIN  = 3'd4,
        SETTLE = 3'd5,
        HALT   = 3'd6
    } state_t;

    logic [EW-1:0]        mem_r [DEPTH];
    logic [AW:0]          wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
    logic                 full_s, empty_s, full_nxt_s, push_s, pop_s;
    logic [EW-1:0]        head_s;
    logic                 head_start_s;
    logic [OPW-1:0]       head_op_s;
    logic [DATAWIDTH-1:0] head_data_s;

    state_t               state_r, state_nxt_s;
    logic [DATAWIDTH-1:0] rcnt_r, rcnt_nxt_s;
    logic [SW-1:0]        scnt_r, scnt_nxt_s, scnt_inc_s;
    logic [OPW-1:0]       cur_op_r, cur_op_nxt_s;

    logic [OPW-1:0]       c_op_nxt_s;
    logic [DATAWIDTH-1:0] c_data_nxt_s;
    logic                 c_start_nxt_s;
    logic                 cap_s, set_timeout_s;
    logic [OPW-1:0]       cap_op_s;

    assign full_s       = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty_s      = (wptr_r == rptr_r);
    assign push_s       = cmd_valid && !full_s;
    assign wptr_nxt_s   = wptr_r + (AW + 1)'(push_s);
    assign rptr_nxt_s   = rptr_r + (AW + 1)'(pop_s);
    assign full_nxt_s   = (wptr_nxt_s[AW] != rptr_nxt_s[AW]) &&
                          (wptr_nxt_s[AW-1:0] == rptr_nxt_s[AW-1:0]);

    assign head_s       = mem_r[rptr_r[AW-1:0]];
    assign head_start_s = head_s[EW-1];
    assign head_op_s    = head_s[EW-2 -: OPW];
    assign head_data_s  = head_s[DATAWIDTH-1:0];

    // Settle counter sticks at SETTLEMAX rather than wrapping.
    assign scnt_inc_s = (scnt_r >= SW'(SETTLEMAX)) ? scnt_r : scnt_r + SW'(1);

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wptr_r <= {(AW + 1){1'b0}};
            rptr_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wptr_r[AW-1:0]] <= {cmd_start, cmd_op, cmd_data};
            end
            wptr_r <= wptr_nxt_s;
            rptr_r <= rptr_nxt_s;
        end
    end

    // FSM next-state, pop decision and next values of the registered controller outputs
    always_comb begin
        state_nxt_s   = state_r;
        pop_s         = 1'b0;
        rcnt_nxt_s    = rcnt_r;
        scnt_nxt_s    = scnt_r;
        cur_op_nxt_s  = cur_op_r;
        c_op_nxt_s    = {OPW{1'b0}};
        c_data_nxt_s  = {DATAWIDTH{1'b0}};
        c_start_nxt_s = 1'b0;
        cap_s         = 1'b0;
        cap_op_s      = {OPW{1'b0}};
        set_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s && ready && !halted) begin
                    pop_s = 1'b1;
                    if (head_start_s) begin
                        state_nxt_s   = ROUND;
                        rcnt_nxt_s    = (head_data_s == {DATAWIDTH{1'b0}}) ? DATAWIDTH'(1) : head_data_s;
                        cur_op_nxt_s  = {OPW{1'b0}};
                        c_start_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = ISSUE;
                        cur_op_nxt_s = head_op_s;
                        c_op_nxt_s   = head_op_s;
                        c_data_nxt_s = head_data_s;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = CHECK;
            end
            CHECK: begin
                if (err != {ERRW{1'b0}}) begin
                    cap_s       = 1'b1;
                    cap_op_s    = cur_op_r;
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROUND: begin
                // Errors are recorded but never cut a round short.
                if (err != {ERRW{1'b0}}) begin
                    cap_s = 1'b1;
                end else begin
                    cap_s = 1'b0;
                end
                if (rcnt_r <= DATAWIDTH'(1)) begin
                    state_nxt_s = DRAIN;
                    scnt_nxt_s  = {SW{1'b0}};
                end else begin
                    rcnt_nxt_s    = rcnt_r - DATAWIDTH'(1);
                    c_start_nxt_s = 1'b1;
                end
            end
            DRAIN: begin
                if (!ready) begin
                    state_nxt_s = SETTLE;
                    scnt_nxt_s  = scnt_inc_s;
                end else if (scnt_inc_s >= SW'(SETTLEMAX)) begin
                    set_timeout_s = 1'b1;
                    state_nxt_s   = IDLE;
                    scnt_nxt_s    = {SW{1'b0}};
                end else begin
                    scnt_nxt_s = scnt_inc_s;
                end
            end
            SETTLE: begin
                if (ready) begin
                    state_nxt_s = IDLE;
                    scnt_nxt_s  = {SW{1'b0}};
                end else if (scnt_inc_s >= SW'(SETTLEMAX)) begin
                    set_timeout_s = 1'b1;
                    state_nxt_s   = IDLE;
                    scnt_nxt_s    = {SW{1'b0}};
                end else begin
                    scnt_nxt_s = scnt_inc_s;
                end
            end
            HALT: begin
                if (clr_err) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and round/settle counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            rcnt_r   <= {DATAWIDTH{1'b0}};
            scnt_r   <= {SW{1'b0}};
            cur_op_r <= {OPW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            rcnt_r   <= rcnt_nxt_s;
            scnt_r   <= scnt_nxt_s;
            cur_op_r <= cur_op_nxt_s;
        end
    end

    // Registered controller port and host-side flow/busy flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            C_op      <= {OPW{1'b0}};
            C_data    <= {DATAWIDTH{1'b0}};
            C_start   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            C_op      <= c_op_nxt_s;
            C_data    <= c_data_nxt_s;
            C_start   <= c_start_nxt_s;
            cmd_ready <= !full_nxt_s;
            busy      <= (wptr_nxt_s != rptr_nxt_s) || (state_nxt_s != IDLE);
        end
    end

    // Sticky status; a fresh capture takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halted   <= 1'b0;
            err_code <= {ERRW{1'b0}};
            err_op   <= {OPW{1'b0}};
            timeout  <= 1'b0;
        end else begin
            if (cap_s) begin
                halted   <= 1'b1;
                err_code <= err;
                err_op   <= cap_op_s;
            end else if (clr_err) begin
                halted   <= 1'b0;
                err_code <= {ERRW{1'b0}};
                err_op   <= {OPW{1'b0}};
            end else begin
                halted   <= halted;
                err_code <= err_code;
                err_op   <= err_op;
            end
            if (set_timeout_s) begin
                timeout <= 1'b1;
            end else if (clr_err) begin
                timeout <= 1'b0;
            end else begin
                timeout <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_bids22_cmd_sequencer.sv
// Directed self-checking bench for bids22_cmd_sequencer; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_bids22_cmd_sequencer;

    localparam logic [3:0] LOADX = 4'd1;
    localparam logic [3:0] LOADY = 4'd2;
    localparam logic [3:0] LOCK  = 4'd3;
    localparam logic [3:0] UNLOCK = 4'd4;
    localparam logic [3:0] ALREADYUNLOCKED = 4'd6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_start;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        ready;
    logic [3:0]  err;
    logic        busy;
    logic        halted;
    logic [3:0]  err_code;
    logic [3:0]  err_op;
    logic        timeout;
    logic        clr_err;

    int errors = 0;
    int checks = 0;

    bids22_cmd_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_start(cmd_start),
        .C_op(C_op), .C_data(C_data), .C_start(C_start), .ready(ready), .err(err),
        .busy(busy), .halted(halted), .err_code(err_code), .err_op(err_op),
        .timeout(timeout), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] data, input logic start);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_start = start;
        tick();
        cmd_valid = 1'b0; cmd_op = 4'd0; cmd_data = 32'd0; cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_data = 32'd0; cmd_start = 1'b0;
        ready = 1'b0; err = 4'd0; clr_err = 1'b0;
        #12;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
        checks++; if (C_op !== 4'd0 || C_data !== 32'd0 || C_start !== 1'b0) begin errors++; $display("FAIL rst_cport: got op=%0h data=%0h start=%0b want 0", C_op, C_data, C_start); end
        checks++; if ({busy, halted, timeout, err_code, err_op} !== 11'd0) begin errors++; $display("FAIL rst_status: got busy=%0b halted=%0b timeout=%0b code=%0h op=%0h want 0", busy, halted, timeout, err_code, err_op); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ops();
        ready = 1'b1;
        push(LOADX, 32'd5, 1'b0);
        checks++; if (C_op !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL ops_accept: got op=%0h busy=%0b want op=0 busy=1", C_op, busy); end
        push(LOCK, 32'hAB, 1'b0);
        checks++; if (C_op !== LOADX || C_data !== 32'd5) begin errors++; $display("FAIL ops_first: got op=%0h data=%0h want 1/5", C_op, C_data); end
        tick();
        checks++; if (C_op !== 4'd0 || C_data !== 32'd0) begin errors++; $display("FAIL ops_one_cycle: got op=%0h data=%0h want 0/0", C_op, C_data); end
        tick();
        checks++; if (C_op !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL ops_gap: got op=%0h busy=%0b want 0/1", C_op, busy); end
        tick();
        checks++; if (C_op !== LOCK || C_data !== 32'hAB) begin errors++; $display("FAIL ops_second: got op=%0h data=%0h want 3/ab", C_op, C_data); end
        tick();
        checks++; if (C_op !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL ops_check: got op=%0h busy=%0b want 0/1", C_op, busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ops_idle: got busy=%0b want 0", busy); end
    endtask

    task automatic test_round();
        int cnt = 0;
        int first = -1;
        push(4'd0, 32'd4, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (C_start === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        checks++; if (cnt !== 4) begin errors++; $display("FAIL round_len: got %0d want 4", cnt); end
        checks++; if (first !== 1) begin errors++; $display("FAIL round_first: got %0d want 1", first); end
        checks++; if (busy !== 1'b1 || C_data !== 32'd0) begin errors++; $display("FAIL round_drain: got busy=%0b data=%0h want 1/0", busy, C_data); end
        ready = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL round_settle: got busy=%0b timeout=%0b want 0/0", busy, timeout); end
    endtask

    task automatic test_halt();
        push(UNLOCK, 32'd0, 1'b0);
        push(LOADY, 32'd7, 1'b0);
        checks++; if (C_op !== UNLOCK) begin errors++; $display("FAIL halt_issue: got %0h want 4", C_op); end
        err = ALREADYUNLOCKED;
        tick();
        tick();
        err = 4'd0;
        checks++; if (halted !== 1'b1 || err_code !== ALREADYUNLOCKED || err_op !== UNLOCK) begin errors++; $display("FAIL halt_capture: got halted=%0b code=%0h op=%0h want 1/6/4", halted, err_code, err_op); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (C_op !== 4'd0 || halted !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL halt_hold: got op=%0h halted=%0b busy=%0b want 0/1/1", C_op, halted, busy); end
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (halted !== 1'b0 || err_code !== 4'd0 || err_op !== 4'd0) begin errors++; $display("FAIL halt_clear: got halted=%0b code=%0h op=%0h want 0", halted, err_code, err_op); end
        tick();
        checks++; if (C_op !== LOADY || C_data !== 32'd7) begin errors++; $display("FAIL halt_resume: got op=%0h data=%0h want 2/7", C_op, C_data); end
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_done: got busy=%0b want 0", busy); end
    endtask

    task automatic test_full();
        logic [3:0]  got_op [$];
        logic [31:0] got_data [$];
        ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %0b want 1", i, cmd_ready); end
            push(4'(i), 32'd100 + 32'(i), 1'b0);
        end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_flag: got %0b want 0", cmd_ready); end
        push(4'd15, 32'd999, 1'b0);
        checks++; if (cmd_ready !== 1'b0 || C_op !== 4'd0) begin errors++; $display("FAIL full_drop: got ready=%0b op=%0h want 0/0", cmd_ready, C_op); end
        ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (C_op !== 4'd0) begin
                got_op.push_back(C_op);
                got_data.push_back(C_data);
            end
        end
        checks++; if (got_op.size() !== 8) begin errors++; $display("FAIL full_count: got %0d want 8", got_op.size()); end
        for (int i = 0; i < 8 && i < got_op.size(); i++) begin
            checks++; if (got_op[i] !== 4'(i + 1) || got_data[i] !== 32'd101 + 32'(i)) begin errors++; $display("FAIL full_order_%0d: got %0h/%0d want %0h/%0d", i, got_op[i], got_data[i], i + 1, 101 + i); end
        end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL full_empty: got busy=%0b ready=%0b want 0/1", busy, cmd_ready); end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        push(4'd0, 32'd0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (C_start === 1'b1) cnt++;
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL to_round1: got %0d want 1", cnt); end
        checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: got timeout=%0b busy=%0b want 0/1", timeout, busy); end
        tick();
        checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_set: got timeout=%0b busy=%0b want 1/0", timeout, busy); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %0b want 0", timeout); end
    endtask

    task automatic test_reset_mid_round();
        push(4'd0, 32'd10, 1'b1);
        err = 4'd5;
        push(LOADX, 32'd1, 1'b0);
        checks++; if (C_start !== 1'b1) begin errors++; $display("FAIL mr_cycle1: got %0b want 1", C_start); end
        tick();
        err = 4'd0;
        checks++; if (C_start !== 1'b1 || halted !== 1'b1 || err_code !== 4'd5 || err_op !== 4'd0) begin errors++; $display("FAIL mr_cycle2: got start=%0b halted=%0b code=%0h op=%0h want 1/1/5/0", C_start, halted, err_code, err_op); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (C_start !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mr_async: got start=%0b busy=%0b ready=%0b want 0/0/1", C_start, busy, cmd_ready); end
        checks++; if ({halted, timeout, err_code, err_op} !== 10'd0) begin errors++; $display("FAIL mr_status: got halted=%0b timeout=%0b code=%0h op=%0h want 0", halted, timeout, err_code, err_op); end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (C_op !== 4'd0 || C_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mr_empty: got op=%0h start=%0b busy=%0b want 0", C_op, C_start, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_round();
        test_halt();
        test_full();
        test_timeout();
        test_reset_mid_round();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
